// File: rtl/lsu_byte_mask_initiator_if.sv
// Byte-masked synchronous SRAM bus: request channel (avalid/aready) and
// read-return channel (rvalid/rready) between an initiator and a responder.
interface lsu_byte_mask_initiator_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 7
);
    logic             avalid;
    logic             aready;
    logic             awren;
    logic [3:0]       astrb;
    logic [ADDRW-1:0] aaddr;
    logic [DATAW-1:0] adata;
    logic             rvalid;
    logic             rready;
    logic [DATAW-1:0] rdata;

    modport master (
        output avalid, awren, astrb, aaddr, adata, rready,
        input  aready, rvalid, rdata
    );

    modport slave (
        input  avalid, awren, astrb, aaddr, adata, rready,
        output aready, rvalid, rdata
    );
endinterface

// File: rtl/lsu_byte_mask_initiator.sv
// LSU-side initiator for a byte-masked SRAM: formats byte/half/word accesses,
// tracks the single outstanding read and returns extended load data.
module lsu_byte_mask_initiator #(
    parameter int DATAW = 32,
    parameter int ADDRW = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [ADDRW+1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DATAW-1:0] resp_data,
    output logic             resp_err,
    output logic             store_err,
    lsu_byte_mask_initiator_if.master mem
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = (off != 2'd0);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] fmt_strb(input logic we, input logic [1:0] size,
                                            input logic [1:0] off);
        if (!we) begin
            fmt_strb = 4'h0;
        end else begin
            case (size)
                SZ_BYTE: fmt_strb = 4'b0001 << off;
                SZ_HALF: fmt_strb = 4'b0011 << off;
                default: fmt_strb = 4'hF;
            endcase
        end
    endfunction

    function automatic logic [DATAW-1:0] fmt_data(input logic [1:0] size,
                                                  input logic [DATAW-1:0] wdata);
        case (size)
            SZ_BYTE: fmt_data = {4{wdata[7:0]}};
            SZ_HALF: fmt_data = {2{wdata[15:0]}};
            default: fmt_data = wdata;
        endcase
    endfunction

    function automatic logic [DATAW-1:0] extend_load(input logic [DATAW-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic sgn);
        logic [DATAW-1:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            SZ_BYTE: extend_load = sgn ? DATAW'(b) : {24'd0, sh[7:0]};
            SZ_HALF: extend_load = sgn ? DATAW'(h) : {16'd0, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    logic             vld_p1;
    logic             wren_p1;
    logic [3:0]       strb_p1;
    logic [ADDRW-1:0] addr_p1;
    logic [DATAW-1:0] data_p1;
    logic [1:0]       off_p1;
    logic [1:0]       size_p1;
    logic             sgn_p1;

    logic             rd_pending;
    logic [1:0]       off_p2;
    logic [1:0]       size_p2;
    logic             sgn_p2;

    logic             err_valid;

    logic [1:0] req_off;
    logic       req_mis;
    logic       req_fire;
    logic       acc_fire;
    logic       read_done;
    logic       bus_blocked;
    logic       a_fire;
    logic       load_fire;
    logic       rd_resp;
    logic       err_show;
    logic       err_take;

    assign req_off  = req_addr[1:0];
    assign req_mis  = misaligned(req_size, req_off);
    assign req_fire = req_valid && req_ready;
    assign acc_fire = req_fire && !req_mis;

    // The responder's read register is clobbered by any access, so hold the
    // bus until the outstanding read data has been taken.
    assign read_done   = rd_pending && mem.rvalid && mem.rready;
    assign bus_blocked = rd_pending && !read_done;
    assign mem.avalid  = vld_p1 && !bus_blocked;
    assign a_fire      = mem.avalid && mem.aready;
    assign load_fire   = a_fire && !wren_p1;

    assign mem.awren = wren_p1;
    assign mem.astrb = strb_p1;
    assign mem.aaddr = addr_p1;
    assign mem.adata = data_p1;
    assign mem.rready = rd_pending && resp_ready;

    // An error response waits behind every older load so order is preserved.
    assign rd_resp    = rd_pending && mem.rvalid;
    assign err_show   = err_valid && !rd_pending && !(vld_p1 && !wren_p1);
    assign err_take   = err_show && resp_ready;
    assign resp_valid = rd_resp || err_show;
    assign resp_err   = err_show;
    assign resp_data  = rd_resp ? extend_load(mem.rdata, off_p2, size_p2, sgn_p2) : '0;

    assign req_ready = (!vld_p1 || a_fire) && !err_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_pending <= 1'b0;
            err_valid  <= 1'b0;
            store_err  <= 1'b0;
        end else begin
            if (acc_fire) begin
                vld_p1 <= 1'b1;
            end else if (a_fire) begin
                vld_p1 <= 1'b0;
            end

            if (load_fire) begin
                rd_pending <= 1'b1;
            end else if (read_done) begin
                rd_pending <= 1'b0;
            end

            if (req_fire && req_mis && !req_we) begin
                err_valid <= 1'b1;
            end else if (err_take) begin
                err_valid <= 1'b0;
            end

            if (req_fire && req_mis && req_we) begin
                store_err <= 1'b1;
            end
        end
    end

    // Stage p1: formatted access; stage p2: alignment of the read in flight.
    always_ff @(posedge clk) begin
        if (acc_fire) begin
            wren_p1 <= req_we;
            strb_p1 <= fmt_strb(req_we, req_size, req_off);
            addr_p1 <= req_addr[ADDRW+1:2];
            data_p1 <= fmt_data(req_size, req_wdata);
            off_p1  <= req_off;
            size_p1 <= req_size;
            sgn_p1  <= req_signed;
        end
        if (load_fire) begin
            off_p2  <= off_p1;
            size_p2 <= size_p1;
            sgn_p2  <= sgn_p1;
        end
    end

endmodule

// File: tb/tb_lsu_byte_mask_initiator.sv
// Directed bench for lsu_byte_mask_initiator with an SRAM responder and a
// byte-level reference model of memory, accesses and responses.
module tb_lsu_byte_mask_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        store_err;
    logic        aready;

    logic        rv_r = 1'b0;
    logic [31:0] rd_r = 32'd0;
    logic        mem_init_done = 1'b0;
    logic [31:0] sram [0:127];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    lsu_byte_mask_initiator_if #(.DATAW(32), .ADDRW(7)) bus ();

    assign bus.aready = aready;
    assign bus.rvalid = rv_r;
    assign bus.rdata  = rd_r;

    lsu_byte_mask_initiator #(.DATAW(32), .ADDRW(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .store_err  (store_err),
        .mem        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int w);
        logic [7:0] b;
        b = w[7:0];
        if (w == 0) return 32'h11223344;
        if (w == 3) return 32'h80FF0000;
        return {b ^ 8'h5A, ~b, b, 8'hC3};
    endfunction

    // SRAM responder: one read register, overwritten by every access.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int w = 0; w < 128; w++) sram[w] <= init_word(w);
            mem_init_done <= 1'b1;
        end else if (bus.avalid && bus.aready) begin
            if (bus.awren) begin
                for (int i = 0; i < 4; i++)
                    if (bus.astrb[i]) sram[bus.aaddr][8*i +: 8] <= bus.adata[8*i +: 8];
                rv_r <= 1'b0;
            end else begin
                rv_r <= 1'b1;
                rd_r <= sram[bus.aaddr];
            end
        end else if (rv_r && bus.rready) begin
            rv_r <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory, expected accesses and responses.
    typedef struct { logic wren; logic [3:0] strb; logic [6:0] addr; logic [31:0] data; } acc_t;
    typedef struct { logic [31:0] data; logic err; } resp_t;

    acc_t  exp_acc[$];
    resp_t exp_resp[$];
    logic [7:0] mb [int];
    logic m_store_err = 1'b0;
    int acc_cyc[$];
    int resp_cyc[$];

    function automatic logic [7:0] mbyte(input int a);
        logic [31:0] w;
        if (mb.exists(a)) return mb[a];
        w = init_word(a / 4);
        return w[8*(a%4) +: 8];
    endfunction

    task automatic model_accept();
        int n, off, ba;
        logic mis;
        acc_t a;
        resp_t r;
        logic [31:0] v;
        ba  = int'(req_addr);
        off = ba % 4;
        n   = 1;
        if (req_size == 2'b11) mis = 1'b1;
        else begin
            n   = 1 << int'(req_size);
            mis = (ba % n) != 0;
        end
        if (mis) begin
            if (req_we) m_store_err = 1'b1;
            else begin
                r.data = 32'd0; r.err = 1'b1;
                exp_resp.push_back(r);
            end
        end else begin
            a.addr = req_addr[8:2]; a.wren = req_we; a.strb = 4'h0; a.data = 32'd0;
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= off && i < off + n) a.strb[i] = 1'b1;
                    a.data[8*i +: 8] = req_wdata[8*(i%n) +: 8];
                end
                for (int k = 0; k < n; k++) mb[ba + k] = req_wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mbyte(ba + k);
                if (req_signed && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                r.data = v; r.err = 1'b0;
                exp_resp.push_back(r);
            end
            exp_acc.push_back(a);
        end
    endtask

    // Compare process: values are stable at the falling edge, and every
    // handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        acc_t e;
        resp_t r;
        if (rst) begin
            exp_acc.delete();
            exp_resp.delete();
            m_store_err = 1'b0;
        end
        chk("store_err", 32'(store_err), 32'(m_store_err));
        if (!rst) begin
            if (bus.avalid && bus.aready) begin
                acc_cyc.push_back(cyc);
                if (exp_acc.size() == 0) chk("unexpected_access", 32'(bus.avalid), 32'd0);
                else begin
                    e = exp_acc.pop_front();
                    chk("acc_wren", 32'(bus.awren), 32'(e.wren));
                    chk("acc_strb", 32'(bus.astrb), 32'(e.strb));
                    chk("acc_addr", 32'(bus.aaddr), 32'(e.addr));
                    if (e.wren) chk("acc_data", bus.adata, e.data);
                end
            end
            if (resp_valid && resp_ready) begin
                resp_cyc.push_back(cyc);
                if (exp_resp.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
                else begin
                    r = exp_resp.pop_front();
                    chk("resp_data", resp_data, r.data);
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                end
            end
            if (req_valid && req_ready) model_accept();
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [8:0] ad, input logic [31:0] wd);
        logic acc;
        acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!acc) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string name, input logic [31:0] exp_d, input logic exp_e);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                chk({name, "_data"}, resp_data, exp_d);
                chk({name, "_err"}, 32'(resp_err), 32'(exp_e));
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, na, nr;
        logic got;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 9'd0; req_wdata = 32'd0;
        aready = 1'b1; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avalid", 32'(bus.avalid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_store_err", 32'(store_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Aligned stores
        issue(1'b1, 2'b10, 1'b0, 9'h08, 32'hDEADBEEF);
        chk("sw_avalid", 32'(bus.avalid), 32'd1);
        chk("sw_awren", 32'(bus.awren), 32'd1);
        chk("sw_aaddr", 32'(bus.aaddr), 32'd2);
        chk("sw_astrb", 32'(bus.astrb), 32'hF);
        chk("sw_adata", bus.adata, 32'hDEADBEEF);
        chk("sw_no_resp", 32'(resp_valid), 32'd0);
        issue(1'b1, 2'b00, 1'b0, 9'h0D, 32'h0000005A);
        chk("sb_aaddr", 32'(bus.aaddr), 32'd3);
        chk("sb_astrb", 32'(bus.astrb), 32'h2);
        chk("sb_adata", bus.adata, 32'h5A5A5A5A);

        // Loads from word 3 (0x80FF0000 with byte 1 now 0x5A)
        issue(1'b0, 2'b00, 1'b1, 9'h0F, 32'd0);
        wait_resp("lb_signed", 32'hFFFFFF80, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 9'h0E, 32'd0);
        wait_resp("lhu", 32'h000080FF, 1'b0);

        // Misaligned load and store
        issue(1'b0, 2'b01, 1'b0, 9'h03, 32'd0);
        chk("mis_load_no_avalid", 32'(bus.avalid), 32'd0);
        wait_resp("mis_load", 32'd0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 9'h06, 32'h12345678);
        chk("mis_store_no_avalid", 32'(bus.avalid), 32'd0);
        chk("mis_store_err", 32'(store_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mis_store_err_sticky", 32'(store_err), 32'd1);

        // Stalled response with a queued store behind it
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 9'h0C, 32'd0);
        issue(1'b1, 2'b00, 1'b0, 9'h00, 32'h00000077);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; break; end
        end
        if (!got) chk("stall_resp_timeout", 32'd0, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_resp_data", resp_data, 32'h80FF5A00);
            chk("stall_no_avalid", 32'(bus.avalid), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Four back-to-back loads
        na = acc_cyc.size();
        nr = resp_cyc.size();
        c0 = cyc;
        issue(1'b0, 2'b10, 1'b0, 9'h00, 32'd0);
        issue(1'b0, 2'b00, 1'b1, 9'h09, 32'd0);
        issue(1'b0, 2'b01, 1'b1, 9'h0A, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 9'h0F, 32'd0);
        chk("b2b_accept_cycles", 32'(cyc - c0), 32'd4);
        for (int i = 0; i < 20 && resp_cyc.size() < nr + 4; i++) @(posedge clk);
        #1;
        if (resp_cyc.size() < nr + 4 || acc_cyc.size() < na + 4) chk("b2b_timeout", 32'd0, 32'd1);
        else begin
            chk("b2b_access_spacing", 32'(acc_cyc[na+3] - acc_cyc[na]), 32'd3);
            chk("b2b_resp_spacing", 32'(resp_cyc[nr+3] - resp_cyc[nr]), 32'd3);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset while a load is pending
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 9'h08, 32'd0);
        @(posedge clk); #1;
        chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #2;
        chk("mid_rst_avalid", 32'(bus.avalid), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
        chk("mid_rst_store_err", 32'(store_err), 32'd0);
        chk("mid_rst_rready", 32'(bus.rready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("stale_rvalid_present", 32'(bus.rvalid), 32'd1);
        chk("stale_rvalid_ignored", 32'(resp_valid), 32'd0);
        chk("stale_rready_low", 32'(bus.rready), 32'd0);
        @(posedge clk); #1;
        chk("stale_still_ignored", 32'(resp_valid), 32'd0);
        issue(1'b0, 2'b01, 1'b1, 9'h0A, 32'd0);
        wait_resp("post_rst_lh", 32'hFFFFDEAD, 1'b0);

        for (int i = 0; i < 50 && (exp_acc.size() != 0 || exp_resp.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain_acc", 32'(exp_acc.size()), 32'd0);
        chk("drain_resp", 32'(exp_resp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
